// File: rtl/reset_sequencer.sv
// Staged reset release for the VGA, game and display domains, with a soft game-restart handshake.
// Define RSTSEQ_FRAME_ALIGN_EN to hold the game release until a frame_start pulse.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic soft_req,
  output logic rst_vga,
  output logic rst_game,
  output logic rst_disp,
  output logic soft_ack,
  output logic ready
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_VGA_UP,
    S_WAIT_FRAME,
    S_GAME_UP,
    S_RUN,
    S_SOFT
  } state_e;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       soft_seq_q, soft_seq_d;
  logic       soft_ack_q, soft_ack_d;
  logic       rst_vga_q, rst_vga_d;
  logic       rst_game_q, rst_game_d;
  logic       rst_disp_q, rst_disp_d;
  logic       ready_q, ready_d;
  logic       cnt_done;
  logic       frame_go;

`ifdef RSTSEQ_FRAME_ALIGN_EN
  assign frame_go = frame_start;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign frame_go = 1'b1;
`endif

  // A count of N expires on the Nth edge after loading, so "1" is the last count.
  assign cnt_done = (cnt_q <= 8'd1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    soft_seq_d = soft_seq_q;
    soft_ack_d = soft_ack_q;

    unique case (state_q)
      S_HOLD: begin
        if (cnt_done) begin
          state_d = S_VGA_UP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_VGA_UP: begin
        if (cnt_done) state_d = S_WAIT_FRAME;
        else          cnt_d   = cnt_q - 8'd1;
      end
      S_WAIT_FRAME: begin
        if (frame_go) begin
          state_d = S_GAME_UP;
          cnt_d   = GAP_LD;
        end
      end
      S_GAME_UP: begin
        if (cnt_done) begin
          state_d = S_RUN;
          if (soft_seq_q) begin
            soft_ack_d = 1'b1;
            soft_seq_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RUN: begin
        // While acknowledged, a still-high request only waits for its own release.
        if (soft_ack_q) begin
          if (!soft_req) soft_ack_d = 1'b0;
        end else if (soft_req) begin
          state_d    = S_SOFT;
          cnt_d      = HOLD_LD;
          soft_seq_d = 1'b1;
        end
      end
      S_SOFT: begin
        if (cnt_done) state_d = S_WAIT_FRAME;
        else          cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
      end
    endcase

    // Outputs decode the next state so they switch on the same edge as the state.
    rst_vga_d  = (state_d == S_HOLD);
    rst_game_d = (state_d inside {S_HOLD, S_VGA_UP, S_WAIT_FRAME, S_SOFT});
    rst_disp_d = (state_d != S_RUN);
    ready_d    = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HOLD;
      cnt_q      <= HOLD_LD;
      soft_seq_q <= 1'b0;
      soft_ack_q <= 1'b0;
      rst_vga_q  <= 1'b1;
      rst_game_q <= 1'b1;
      rst_disp_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      soft_seq_q <= soft_seq_d;
      soft_ack_q <= soft_ack_d;
      rst_vga_q  <= rst_vga_d;
      rst_game_q <= rst_game_d;
      rst_disp_q <= rst_disp_d;
      ready_q    <= ready_d;
    end
  end

  assign rst_vga  = rst_vga_q;
  assign rst_game = rst_game_q;
  assign rst_disp = rst_disp_q;
  assign soft_ack = soft_ack_q;
  assign ready    = ready_q;

endmodule
